sprite_move_scheduler: RTL and testbench
========================================

Name: sprite_move_scheduler

Overview:
- Sequences per-tick movement of pacman and ghosts by sharing one maze-legality lookup port among N_SPRITES sprites.
- On each game tick it queries legality at each sprite's current position in fixed order (sprite 0 = pacman first), then applies that sprite's requested direction.
- Holds authoritative sprite positions and facing bits, which feed the renderer and the ROM mirroring logic.

Parameters:
- N_SPRITES, 4, number of sprites; index 0 is pacman.
- STEP, 2, pixels moved per legal move.
- INIT_X, {10'd390,10'd360,10'd330,10'd360}, flattened reset x per sprite; sprite 0 is in the LSBs.
- INIT_Y, {10'd244,10'd244,10'd244,10'd154}, flattened reset y per sprite.
- TIMEOUT, 15, maximum cycles to wait for a lookup response.

Ports:
- clk  in  1  master clock.
- rst  in  1  reset.
- tick  in  1  single-cycle game-rate strobe, synchronous to clk.
- dir_req  in  4*N_SPRITES  per-sprite requested direction {l,r,u,d}; bit3 = l, bit0 = d.
- lk_req_valid  out  1  lookup request valid.
- lk_req_ready  in  1  lookup port accepts the request.
- lk_x  out  10  x position of the queried sprite.
- lk_y  out  10  y position of the queried sprite.
- lk_rsp_valid  in  1  lookup result valid.
- lk_rsp_legal  in  4  legal moves {l,r,u,d}.
- pos_x  out  10*N_SPRITES  sprite x positions, flattened.
- pos_y  out  10*N_SPRITES  sprite y positions, flattened.
- facing_left  out  N_SPRITES  per-sprite mirror select.
- busy  out  1  a tick sequence is in progress.
- done  out  1  one-cycle pulse when all sprites have been processed.
- timeout_err  out  1  sticky; set when a lookup times out.
- overrun_err  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset and clock: rst is asynchronous, active-high; the clock is clk.
- Reset values:
  - pos_x = INIT_X, pos_y = INIT_Y.
  - facing_left = 0.
  - lk_req_valid, busy, done, timeout_err, overrun_err = 0.
  - Internal: state = IDLE, sprite index idx = 0, wait counter = 0.
  - lk_x and lk_y are don't-care at reset, but are driven from pos of idx at all times.
- FSM states: IDLE, REQ, WAIT, APPLY, DONE.
- IDLE:
  - tick=1 -> REQ, idx=0, busy=1 on the next cycle.
  - tick=0 -> stay in IDLE.
- REQ:
  - lk_req_valid=1, with lk_x/lk_y held stable.
  - Handshake completes when lk_req_valid and lk_req_ready are both 1 in the same cycle -> WAIT, wait counter cleared.
  - lk_req_valid must not drop before the handshake completes.
- WAIT:
  - lk_req_valid=0.
  - lk_rsp_valid=1 -> capture lk_rsp_legal -> APPLY.
  - Wait counter reaches TIMEOUT with no response -> captured legal = 4'b0000, timeout_err <= 1 -> APPLY.
- APPLY (one cycle), using dir_req slice idx sampled in this cycle. Priority is r > l > u > d; only the highest set request bit is considered.
  - r: facing_left[idx] <= 0 unconditionally; if legal r, x += STEP.
  - l: if legal l, x -= STEP and facing_left[idx] <= 1.
  - u: if legal u, y -= STEP.
  - d: if legal d, y += STEP.
  - No request bit set: no change.
  - Then, if idx == N_SPRITES-1 -> DONE; else idx++ -> REQ.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- Arithmetic: position arithmetic is 10-bit modular; wrap on underflow/overflow is accepted. Legality is the maze's job.
- Latency with zero-wait handshakes and a next-cycle response: 3 cycles per sprite plus 2 cycles of overhead (14 cycles for N=4) from tick to done.
- lk_rsp_valid outside WAIT is ignored.
- tick while busy: ignored, overrun_err <= 1; the in-flight sequence continues unaffected.
- Sticky flags clear only on rst.
- rst mid-sequence: immediate return to reset values; any partial update is discarded, and a pending lookup is abandoned with no response expected.
- Positions change only in APPLY; the renderer may sample them at any time.

Decomposition:
- Shared package (pacman_pkg):
  - Direction bit indices (DIR_L=3, DIR_R=2, DIR_U=1, DIR_D=0).
  - FSM state encoding.
  - Position width constant POS_W=10.
- Sub-module move_apply (combinational): takes pos, facing, dir, legal and STEP; returns next pos and facing. It is reused by a future ghost AI block.

Test Plan:
- Reset -> pos_x[9:0]=360, pos_y[9:0]=154, sprite 3 at (390,244), all flags 0, busy=0.
- tick, sprite 0 dir=r, legal=4'b0100, ready always 1, rsp one cycle later -> sprite 0 x=362, facing_left[0]=0, done pulses 14 cycles after tick.
- Sprite 1 dir = l|u both set, legal = 4'b0010 (up only) -> no move (left has priority and is illegal), facing_left[1] unchanged.
- Sprite 2 dir=l, legal=4'b1000 -> x 360->358, facing_left[2]=1; next tick dir=r, legal=0 -> x stays 358, facing_left[2]=0.
- Lookup never responds for sprite 0 -> after 15 wait cycles timeout_err=1, sprite 0 unmoved, sprites 1..3 still processed, done pulses.
- Second tick while busy -> overrun_err=1, only one done pulse. Assert rst during WAIT of sprite 2 -> all positions return to INIT, busy=0 immediately.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared constants and types for the sprite movement datapath.
// Direction vectors everywhere are packed {l,r,u,d}.
package pacman_pkg;

  localparam int POS_W = 10;

  localparam int DIR_L = 3;
  localparam int DIR_R = 2;
  localparam int DIR_U = 1;
  localparam int DIR_D = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_APPLY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/move_apply.sv
// Combinational single-sprite move: picks the highest-priority requested
// direction (r > l > u > d) and moves only if the maze says it is legal.
module move_apply
  import pacman_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  input  logic             facing,
  input  logic [3:0]       dir,
  input  logic [3:0]       legal,
  output logic [POS_W-1:0] x_next,
  output logic [POS_W-1:0] y_next,
  output logic             facing_next
);

  localparam logic [POS_W-1:0] STEP_W = POS_W'(STEP);

  // Requesting right always un-mirrors, even into a wall; left mirrors only on a real move.
  always_comb begin
    x_next      = x;
    y_next      = y;
    facing_next = facing;
    if (dir[DIR_R]) begin
      facing_next = 1'b0;
      if (legal[DIR_R]) x_next = x + STEP_W;
    end else if (dir[DIR_L]) begin
      if (legal[DIR_L]) begin
        x_next      = x - STEP_W;
        facing_next = 1'b1;
      end
    end else if (dir[DIR_U]) begin
      if (legal[DIR_U]) y_next = y - STEP_W;
    end else if (dir[DIR_D]) begin
      if (legal[DIR_D]) y_next = y + STEP_W;
    end
  end

endmodule

// File: rtl/sprite_move_scheduler.sv
// Per-tick sprite movement sequencer sharing one maze-legality lookup port.
// state | meaning: IDLE wait tick | REQ lookup request | WAIT lookup response | APPLY move sprite idx | DONE pulse done
module sprite_move_scheduler
  import pacman_pkg::*;
#(
  parameter int                         N_SPRITES = 4,
  parameter int                         STEP      = 2,
  parameter logic [POS_W*N_SPRITES-1:0] INIT_X    = {10'd390, 10'd360, 10'd330, 10'd360},
  parameter logic [POS_W*N_SPRITES-1:0] INIT_Y    = {10'd244, 10'd244, 10'd244, 10'd154},
  parameter int                         TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [4*N_SPRITES-1:0]       dir_req,
  output logic                         lk_req_valid,
  input  logic                         lk_req_ready,
  output logic [POS_W-1:0]             lk_x,
  output logic [POS_W-1:0]             lk_y,
  input  logic                         lk_rsp_valid,
  input  logic [3:0]                   lk_rsp_legal,
  output logic [POS_W*N_SPRITES-1:0]   pos_x,
  output logic [POS_W*N_SPRITES-1:0]   pos_y,
  output logic [N_SPRITES-1:0]         facing_left,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic                         overrun_err
);

  localparam int               IDX_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       legal_q;
  logic             timed_out;
  logic [POS_W-1:0] nx_x, nx_y;
  logic             nx_facing;

  assign lk_x = pos_x[POS_W*idx +: POS_W];
  assign lk_y = pos_y[POS_W*idx +: POS_W];

  move_apply #(.STEP(STEP)) u_move_apply (
    .x           (lk_x),
    .y           (lk_y),
    .facing      (facing_left[idx]),
    .dir         (dir_req[4*idx +: 4]),
    .legal       (legal_q),
    .x_next      (nx_x),
    .y_next      (nx_y),
    .facing_next (nx_facing)
  );

  always_comb begin
    state_nx     = state;
    lk_req_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    timed_out    = 1'b0;
    case (state)
      ST_IDLE: if (tick) state_nx = ST_REQ;
      ST_REQ: begin
        lk_req_valid = 1'b1;
        busy         = 1'b1;
        if (lk_req_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (lk_rsp_valid) begin
          state_nx = ST_APPLY;
        end else if (wait_cnt == CNT_MAX) begin
          timed_out = 1'b1;
          state_nx  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        busy     = 1'b1;
        state_nx = (idx == LAST_IDX) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A tick anywhere outside IDLE (DONE included) cannot start a sequence, so it counts as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      legal_q     <= '0;
      pos_x       <= INIT_X;
      pos_y       <= INIT_Y;
      facing_left <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (tick && state != ST_IDLE) overrun_err <= 1'b1;
      case (state)
        ST_IDLE: if (tick) idx <= '0;
        ST_REQ:  if (lk_req_ready) wait_cnt <= '0;
        ST_WAIT: begin
          if (lk_rsp_valid) begin
            legal_q <= lk_rsp_legal;
          end else if (timed_out) begin
            legal_q     <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_APPLY: begin
          pos_x[POS_W*idx +: POS_W] <= nx_x;
          pos_y[POS_W*idx +: POS_W] <= nx_y;
          facing_left[idx]          <= nx_facing;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Scoreboard bench for sprite_move_scheduler: a reactive lookup agent, a done
// monitor, and a plain-arithmetic movement model computing expected results.
module tb_sprite_move_scheduler;

  localparam int N       = 4;
  localparam int STEP    = 2;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [4*N-1:0] dir_req = '0;
  logic          lk_req_valid, lk_req_ready;
  logic [9:0]    lk_x, lk_y;
  logic          lk_rsp_valid;
  logic [3:0]    lk_rsp_legal;
  logic [10*N-1:0] pos_x, pos_y;
  logic [N-1:0]  facing_left;
  logic          busy, done, timeout_err, overrun_err;

  sprite_move_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .dir_req(dir_req),
    .lk_req_valid(lk_req_valid), .lk_req_ready(lk_req_ready),
    .lk_x(lk_x), .lk_y(lk_y),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_legal(lk_rsp_legal),
    .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left),
    .busy(busy), .done(done), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10*N-1:0] px;
    logic [10*N-1:0] py;
    logic [N-1:0]    f;
    logic            terr;
    logic            oerr;
    int              t0;
    int              lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  // model state and per-tick stimulus plan
  int       mx[N], my[N];
  bit       mf[N];
  bit       m_terr, m_oerr;
  int       s_x[N], s_y[N];
  logic [3:0] t_dir[N], t_legal[N];
  bit       t_drop[N];
  int       t_rdy[N], t_dly[N];
  int       req_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic void model_reset();
    mx = '{360, 330, 360, 390};
    my = '{154, 244, 244, 244};
    for (int i = 0; i < N; i++) mf[i] = 1'b0;
    m_terr = 1'b0;
    m_oerr = 1'b0;
  endfunction

  function automatic void model_move(input int i, input logic [3:0] d, input logic [3:0] lg);
    if (d[2]) begin
      mf[i] = 1'b0;
      if (lg[2]) mx[i] = (mx[i] + STEP) % 1024;
    end else if (d[3]) begin
      if (lg[3]) begin
        mx[i] = (mx[i] - STEP + 1024) % 1024;
        mf[i] = 1'b1;
      end
    end else if (d[1]) begin
      if (lg[1]) my[i] = (my[i] - STEP + 1024) % 1024;
    end else if (d[0]) begin
      if (lg[0]) my[i] = (my[i] + STEP) % 1024;
    end
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.px[10*i +: 10] = 10'(mx[i]);
      e.py[10*i +: 10] = 10'(my[i]);
      e.f[i]           = mf[i];
    end
    e.terr = m_terr;
    e.oerr = m_oerr;
    e.t0   = 0;
    e.lat  = -1;
    return e;
  endfunction

  // Lookup-port agent: stalls ready per plan, answers after the planned delay or never.
  initial begin
    int rq_cycles = 0;
    bit pend = 0;
    bit pend_drop = 0;
    int pend_dly = 0;
    logic [3:0] pend_lg = '0;
    lk_req_ready = 1'b0;
    lk_rsp_valid = 1'b0;
    lk_rsp_legal = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pend = 0; rq_cycles = 0;
        lk_rsp_valid = 1'b0; lk_req_ready = 1'b0;
        continue;
      end
      lk_rsp_valid = 1'b0;
      if (pend && pend_drop && !busy) pend = 0;
      if (pend && !pend_drop) begin
        pend_dly--;
        if (pend_dly == 0) begin
          lk_rsp_valid = 1'b1;
          lk_rsp_legal = pend_lg;
          pend = 0;
        end
      end else if (!pend && !busy && $urandom_range(3) == 0) begin
        lk_rsp_valid = 1'b1;
        lk_rsp_legal = 4'($urandom);
      end
      if (lk_req_valid) begin
        lk_req_ready = (req_n < N) ? (rq_cycles >= t_rdy[req_n]) : 1'b1;
        rq_cycles++;
      end else begin
        rq_cycles = 0;
        lk_req_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (!rst && lk_req_valid && lk_req_ready && req_n < N) begin
        chk($sformatf("lk_x[%0d]", req_n), 64'(lk_x), 64'(s_x[req_n]));
        chk($sformatf("lk_y[%0d]", req_n), 64'(lk_y), 64'(s_y[req_n]));
        pend      = 1;
        pend_drop = t_drop[req_n];
        pend_dly  = t_dly[req_n];
        pend_lg   = t_legal[req_n];
        req_n++;
      end
    end
  end

  // Done monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending tick", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pos_x", 64'(pos_x), 64'(mon_e.px));
          chk("pos_y", 64'(pos_y), 64'(mon_e.py));
          chk("facing_left", 64'(facing_left), 64'(mon_e.f));
          chk("timeout_err", 64'(timeout_err), 64'(mon_e.terr));
          chk("overrun_err", 64'(overrun_err), 64'(mon_e.oerr));
          chk("busy_at_done", 64'(busy), 64'(0));
          if (mon_e.lat >= 0) chk("latency", 64'(cyc - mon_e.t0 + 1), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic plan_random();
    for (int i = 0; i < N; i++) begin
      t_dir[i]   = 4'($urandom);
      t_legal[i] = 4'($urandom);
      t_drop[i]  = ($urandom_range(9) == 0);
      t_rdy[i]   = $urandom_range(3);
      t_dly[i]   = $urandom_range(TIMEOUT, 1);
    end
  endtask

  task automatic plan_fast();
    for (int i = 0; i < N; i++) begin
      t_dir[i] = 4'b0000; t_legal[i] = 4'b0000;
      t_drop[i] = 0; t_rdy[i] = 0; t_dly[i] = 1;
    end
  endtask

  task automatic load_plan();
    for (int i = 0; i < N; i++) begin
      s_x[i] = mx[i];
      s_y[i] = my[i];
      dir_req[4*i +: 4] = t_dir[i];
    end
  endtask

  task automatic run_tick(input bit do_overrun);
    exp_t e;
    int lat;
    int start;
    load_plan();
    lat = 2;
    for (int i = 0; i < N; i++) begin
      model_move(i, t_dir[i], t_drop[i] ? 4'b0000 : t_legal[i]);
      lat += t_rdy[i] + 2 + (t_drop[i] ? TIMEOUT : t_dly[i]);
      if (t_drop[i]) m_terr = 1'b1;
    end
    if (do_overrun) m_oerr = 1'b1;
    e = model_pack();
    e.lat = lat;
    req_n = 0;
    start = n_done;
    @(posedge clk); #1;
    tick = 1'b1;
    e.t0 = cyc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    tick = 1'b0;
    if (do_overrun) begin
      repeat (4) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
    for (int k = 0; k < 600 && n_done == start; k++) @(posedge clk);
    if (n_done == start) begin
      n_vec++; n_err++;
      $display("FAIL done_wait: got no done within 600 cycles expected one pulse");
    end
    repeat (3) @(posedge clk);
    if (do_overrun) chk("single_done", 64'(n_done - start), 64'(1));
  endtask

  initial begin
    model_reset();
    plan_fast();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos_x", 64'(pos_x), 64'({10'd390, 10'd360, 10'd330, 10'd360}));
    chk("rst_pos_y", 64'(pos_y), 64'({10'd244, 10'd244, 10'd244, 10'd154}));
    chk("rst_facing", 64'(facing_left), 64'(0));
    chk("rst_flags", 64'({lk_req_valid, busy, done, timeout_err, overrun_err}), 64'(0));
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);

    // r legal; l|u with only u legal (l wins, no move); l legal
    plan_fast();
    t_dir[0] = 4'b0100; t_legal[0] = 4'b0100;
    t_dir[1] = 4'b1010; t_legal[1] = 4'b0010;
    t_dir[2] = 4'b1000; t_legal[2] = 4'b1000;
    run_tick(1'b0);
    chk("s0_x_362", 64'(pos_x[9:0]), 64'(362));
    chk("s1_unmoved", 64'({pos_x[19:10], pos_y[19:10], facing_left[1]}), 64'({10'd330, 10'd244, 1'b0}));
    chk("s2_left", 64'({pos_x[29:20], facing_left[2]}), 64'({10'd358, 1'b1}));

    // right into a wall: no move but un-mirrors
    plan_fast();
    t_dir[2] = 4'b0100; t_legal[2] = 4'b0000;
    run_tick(1'b0);
    chk("s2_right_wall", 64'({pos_x[29:20], facing_left[2]}), 64'({10'd358, 1'b0}));

    // sprite 0 lookup never answers
    plan_random();
    t_drop[0] = 1; t_dir[0] = 4'b0100; t_legal[0] = 4'b0100;
    for (int i = 1; i < N; i++) t_drop[i] = 0;
    run_tick(1'b0);
    chk("timeout_set", 64'(timeout_err), 64'(1));

    // second tick while busy
    plan_random();
    run_tick(1'b1);

    for (int r = 0; r < 30; r++) begin
      plan_random();
      run_tick(1'b0);
    end

    // reset while waiting on sprite 2's lookup
    plan_random();
    for (int i = 0; i < N; i++) begin t_drop[i] = 0; t_rdy[i] = 0; t_dly[i] = 1; end
    t_dly[2] = 6;
    load_plan();
    req_n = 0;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    for (int k = 0; k < 200 && req_n < 3; k++) @(posedge clk);
    if (req_n < 3) begin
      n_vec++; n_err++;
      $display("FAIL reach_wait2: got %0d requests expected 3", req_n);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pos_x", 64'(pos_x), 64'({10'd390, 10'd360, 10'd330, 10'd360}));
    chk("mid_rst_pos_y", 64'(pos_y), 64'({10'd244, 10'd244, 10'd244, 10'd154}));
    chk("mid_rst_flags", 64'({busy, lk_req_valid, facing_left, timeout_err, overrun_err}), 64'(0));
    model_reset();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 3; r++) begin
      plan_random();
      run_tick(1'b0);
    end

    repeat (10) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
